// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default widths for the data-RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_sat_counter.sv
// N-bit saturating up-counter with asynchronous active-low clear.
module ram_port_arbiter_sat_counter #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [N-1:0] count
);

  localparam logic [N-1:0] MAX = {N{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + N'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of the single data-RAM port between CPU and DMA requesters,
// with a three-state access sequencer and per-requester wait-cycle counters.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  cpu_wait_cnt,
  output logic [CNT_W-1:0]  dma_wait_cnt
);

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  owner_t last_owner, last_owner_nxt;
  logic   txn_we, txn_we_nxt;

  logic              in_issue;
  logic              in_resp;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              other_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_DMA;
      txn_we     <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      txn_we     <= txn_we_nxt;
    end
  end

  // The current owner's request is masked in RESP; only the other side can chain an ISSUE.
  assign other_req = (owner == OWN_CPU) ? dma_req : cpu_req;

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    txn_we_nxt     = txn_we;
    case (state)
      ST_IDLE: begin
        if (cpu_req && dma_req) begin
          owner_nxt = other_owner(last_owner);
          state_nxt = ST_ISSUE;
        end else if (cpu_req) begin
          owner_nxt = OWN_CPU;
          state_nxt = ST_ISSUE;
        end else if (dma_req) begin
          owner_nxt = OWN_DMA;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        txn_we_nxt = sel_we;
        state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        last_owner_nxt = owner;
        if (other_req) begin
          owner_nxt = other_owner(owner);
          state_nxt = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_issue  = (state == ST_ISSUE);
  assign in_resp   = (state == ST_RESP);

  // Request fields are taken live from the registered owner during ISSUE.
  assign sel_we    = (owner == OWN_CPU) ? cpu_we    : dma_we;
  assign sel_addr  = (owner == OWN_CPU) ? cpu_addr  : dma_addr;
  assign sel_wdata = (owner == OWN_CPU) ? cpu_wdata : dma_wdata;

  assign ram_en    = in_issue;
  assign ram_we    = in_issue & sel_we;
  assign ram_addr  = in_issue ? sel_addr  : '0;
  assign ram_wdata = in_issue ? sel_wdata : '0;

  assign cpu_ack   = in_resp & (owner == OWN_CPU);
  assign dma_ack   = in_resp & (owner == OWN_DMA);
  assign cpu_rdata = (cpu_ack && !txn_we) ? ram_rdata : '0;
  assign dma_rdata = (dma_ack && !txn_we) ? ram_rdata : '0;
  assign cpu_stall = cpu_req & ~cpu_ack;

  ram_port_arbiter_sat_counter #(.N(CNT_W)) u_cpu_wait (
    .clk   (clock),
    .rst_n (reset),
    .inc   (cpu_req & ~((owner == OWN_CPU) & (in_issue | in_resp))),
    .count (cpu_wait_cnt)
  );

  ram_port_arbiter_sat_counter #(.N(CNT_W)) u_dma_wait (
    .clk   (clock),
    .rst_n (reset),
    .inc   (dma_req & ~((owner == OWN_DMA) & (in_issue | in_resp))),
    .count (dma_wait_cnt)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural 256x64 sync-read RAM.
module tb_ram_port_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;

  logic              clock;
  logic              reset;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_ack, dma_ack, cpu_stall;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [CNT_W-1:0]  cpu_wait_cnt, dma_wait_cnt;

  logic [DATA_W-1:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .cpu_wait_cnt(cpu_wait_cnt), .dma_wait_cnt(dma_wait_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read-first synchronous RAM.
  always @(posedge clock) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_wdata;
    end
  end

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000, 24'h0, 8'(i)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);

    // Reset held with both requesters active.
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h44; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h55; dma_wdata = '0;
    repeat (3) tick();
    check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_dma_ack", 64'(dma_ack), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_cpu_cnt", 64'(cpu_wait_cnt), 64'd0);
    check("rst_dma_cnt", 64'(dma_wait_cnt), 64'd0);
    reset = 1'b1;
    tick();
    check("t1_grant_en", 64'(ram_en), 64'd1);
    check("t1_grant_cpu_addr", 64'(ram_addr), 64'h44);
    check("t1_cpu_cnt", 64'(cpu_wait_cnt), 64'd1);
    check("t1_dma_cnt", 64'(dma_wait_cnt), 64'd1);
    tick();
    check("t1_cpu_ack", 64'(cpu_ack), 64'd1);
    check("t1_dma_ack_lo", 64'(dma_ack), 64'd0);
    cpu_req = 1'b0;
    tick();
    check("t1_dma_issue_addr", 64'(ram_addr), 64'h55);
    tick();
    check("t1_dma_ack", 64'(dma_ack), 64'd1);
    dma_req = 1'b0;
    tick();
    check("t1_idle_en", 64'(ram_en), 64'd0);

    // CPU store then load at 0x10.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 64'h0000_0000_DEAD_BEEF;
    tick();
    check("t2_st_en", 64'(ram_en), 64'd1);
    check("t2_st_we", 64'(ram_we), 64'd1);
    check("t2_st_addr", 64'(ram_addr), 64'h10);
    check("t2_st_wdata", ram_wdata, 64'h0000_0000_DEAD_BEEF);
    check("t2_st_stall", 64'(cpu_stall), 64'd1);
    check("t2_st_ack_lo", 64'(cpu_ack), 64'd0);
    tick();
    check("t2_st_ack", 64'(cpu_ack), 64'd1);
    check("t2_st_rdata", cpu_rdata, 64'd0);
    check("t2_st_stall_lo", 64'(cpu_stall), 64'd0);
    cpu_we = 1'b0; cpu_wdata = '0;
    tick();
    check("t2_ld_idle_ack", 64'(cpu_ack), 64'd0);
    check("t2_ld_idle_en", 64'(ram_en), 64'd0);
    check("t2_ld_stall", 64'(cpu_stall), 64'd1);
    tick();
    check("t2_ld_we", 64'(ram_we), 64'd0);
    check("t2_ld_addr", 64'(ram_addr), 64'h10);
    tick();
    check("t2_ld_ack", 64'(cpu_ack), 64'd1);
    check("t2_ld_rdata", cpu_rdata, 64'h0000_0000_DEAD_BEEF);
    cpu_req = 1'b0;

    // Both requesting continuously: grants alternate.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 8'h20;
    dma_req = 1'b1; dma_addr = 8'h30;
    for (int r = 0; r < 2; r++) begin
      tick();
      check("t3_cpu_issue_addr", 64'(ram_addr), 64'h20);
      check("t3_cpu_issue_acks", 64'({cpu_ack, dma_ack}), 64'd0);
      tick();
      check("t3_cpu_ack", 64'({cpu_ack, dma_ack}), 64'b10);
      check("t3_cpu_rdata", cpu_rdata, pat(8'h20));
      tick();
      check("t3_dma_issue_addr", 64'(ram_addr), 64'h30);
      tick();
      check("t3_dma_ack", 64'({cpu_ack, dma_ack}), 64'b01);
      check("t3_dma_rdata", dma_rdata, pat(8'h30));
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // DMA alone reads the top word.
    do_reset();
    dma_req = 1'b1; dma_addr = 8'hFF;
    tick();
    check("t4_issue_addr", 64'(ram_addr), 64'hFF);
    check("t4_issue_we", 64'(ram_we), 64'd0);
    tick();
    check("t4_dma_ack", 64'(dma_ack), 64'd1);
    check("t4_dma_rdata", dma_rdata, pat(8'hFF));
    check("t4_cpu_ack", 64'(cpu_ack), 64'd0);
    check("t4_cpu_rdata", cpu_rdata, 64'd0);
    dma_req = 1'b0;
    tick();
    check("t4_dma_ack_lo", 64'(dma_ack), 64'd0);
    check("t4_dma_rdata_lo", dma_rdata, 64'd0);

    // Reset pulse in the middle of a DMA write ISSUE.
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 64'h1234;
    tick();
    check("t5_issue_we", 64'(ram_we), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_we", 64'(ram_we), 64'd0);
    check("t5_async_en", 64'(ram_en), 64'd0);
    dma_req = 1'b0; dma_we = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("t5_no_ack0", 64'(dma_ack), 64'd0);
    check("t5_idle_en", 64'(ram_en), 64'd0);
    tick();
    check("t5_no_ack1", 64'(dma_ack), 64'd0);

    // Wait counters saturate at 2^CNT_W-1 under sustained contention.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 8'h01;
    dma_req = 1'b1; dma_addr = 8'h02;
    tick();
    check("t6_cnt_cpu1", 64'(cpu_wait_cnt), 64'd1);
    check("t6_cnt_dma1", 64'(dma_wait_cnt), 64'd1);
    tick();
    tick();
    check("t6_cnt_cpu3", 64'(cpu_wait_cnt), 64'd1);
    check("t6_cnt_dma3", 64'(dma_wait_cnt), 64'd3);
    repeat (37) tick();
    check("t6_cnt_dma_sat", 64'(dma_wait_cnt), 64'd15);
    check("t6_cnt_cpu_sat", 64'(cpu_wait_cnt), 64'd15);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
